// File: rtl/e_mdu_ctrl.sv
// E-stage multiply/divide sequencer: owns HI/LO, runs mult/div as fixed-latency
// operations and requests a stall while a following MD-class op would collide.
module e_mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Start,
  input  logic [3:0]  MDop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        D_IsMD,
  output logic        Busy,
  output logic        Stall_MD,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] Result
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  state_t r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_hi, r_lo, r_res_hi, r_res_lo;
  logic        w_is_long, w_launch, w_commit;
  logic signed [63:0] w_prod_s;
  logic [63:0] w_prod_u, w_res;

  // Returns {remainder, quotient}; quotient truncates toward zero and the
  // remainder follows the dividend's sign. Magnitude form keeps 0x80000000/-1 exact.
  function automatic logic [63:0] f_div_signed(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ua, ub, q, r;
    ua = a[31] ? -a : a;
    ub = b[31] ? -b : b;
    q  = ua / ub;
    r  = ua % ub;
    if (a[31] ^ b[31]) q = -q;
    if (a[31]) r = -r;
    return {r, q};
  endfunction

  assign w_is_long = (MDop >= 4'd1) && (MDop <= 4'd4);
  assign w_launch  = Start && w_is_long && (r_state == IDLE);
  assign w_commit  = (r_state == RUN) && (r_cnt == 4'd1);

  assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign w_prod_u = {32'b0, A} * {32'b0, B};

  // A zero divisor captures the current HI/LO so the commit leaves them intact.
  always_comb begin
    w_res = {r_hi, r_lo};
    case (MDop)
      4'd1: w_res = w_prod_s;
      4'd2: w_res = w_prod_u;
      4'd3: if (B != 32'd0) w_res = f_div_signed(A, B);
      4'd4: if (B != 32'd0) w_res = {A % B, A / B};
      default: w_res = {r_hi, r_lo};
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_launch) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = (MDop <= 4'd2) ? MULT_CNT : DIV_CNT;
        end
      end
      RUN: begin
        if (r_cnt == 4'd1) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_res_hi <= 32'd0;
      r_res_lo <= 32'd0;
    end else begin
      if (w_launch) begin
        r_res_hi <= w_res[63:32];
        r_res_lo <= w_res[31:0];
      end
      if (w_commit) begin
        r_hi <= r_res_hi;
        r_lo <= r_res_lo;
      end else if (Start && (r_state == IDLE)) begin
        if (MDop == 4'd5) r_hi <= A;
        if (MDop == 4'd6) r_lo <= A;
      end
    end
  end

  assign Busy     = (r_state == RUN);
  assign Stall_MD = D_IsMD && (Busy || (Start && w_is_long));
  assign HI       = r_hi;
  assign LO       = r_lo;

  always_comb begin
    Result = 32'd0;
    if (MDop == 4'd7) Result = r_hi;
    if (MDop == 4'd8) Result = r_lo;
  end

  // The hazard unit must hold any MD op out of E while an operation runs.
  a_no_start_in_run: assert property (@(posedge Clk) disable iff (!Reset_n) !(Busy && Start));

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Bench for e_mdu_ctrl: directed cases with literal results plus random traffic
// compared every cycle against an arithmetic model of HI/LO and the busy window.
module tb_e_mdu_ctrl;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        Clk = 1'b0;
  logic        Reset_n, Start, D_IsMD;
  logic [3:0]  MDop;
  logic [31:0] A, B;
  logic        Busy, Stall_MD;
  logic [31:0] HI, LO, Result;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  e_mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .MDop(MDop), .A(A), .B(B),
    .D_IsMD(D_IsMD), .Busy(Busy), .Stall_MD(Stall_MD), .HI(HI), .LO(LO), .Result(Result)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference result {hi,lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_md(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] hi,
                                         input logic [31:0] lo);
    longint sp, sq, sr;
    longint unsigned up;
    ref_md = {hi, lo};
    case (op)
      4'd1: begin sp = longint'($signed(a)) * longint'($signed(b)); ref_md = sp; end
      4'd2: begin up = 64'(a) * 64'(b); ref_md = up; end
      4'd3: if (b != 0) begin
        sq = longint'($signed(a)) / longint'($signed(b));
        sr = longint'($signed(a)) % longint'($signed(b));
        ref_md = {sr[31:0], sq[31:0]};
      end
      4'd4: if (b != 0) ref_md = {a % b, a / b};
      default: ref_md = {hi, lo};
    endcase
  endfunction

  logic [31:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0;
  int m_left = 0;
  logic [63:0] m_tmp;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_hi = 0; m_lo = 0; m_left = 0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin m_hi = m_phi; m_lo = m_plo; end
    end else if (Start) begin
      if (MDop >= 1 && MDop <= 4) begin
        m_tmp = ref_md(MDop, A, B, m_hi, m_lo);
        m_phi = m_tmp[63:32];
        m_plo = m_tmp[31:0];
        m_left = (MDop <= 2) ? MC : DC;
      end else if (MDop == 5) m_hi = A;
      else if (MDop == 6) m_lo = A;
    end
  end

  always @(negedge Clk) begin
    logic eb, es;
    logic [31:0] er;
    eb = (m_left > 0);
    es = D_IsMD && (eb || (Start && MDop >= 1 && MDop <= 4));
    er = (MDop == 7) ? m_hi : (MDop == 8) ? m_lo : 32'd0;
    check("cyc_busy", {31'b0, Busy}, {31'b0, eb});
    check("cyc_stall", {31'b0, Stall_MD}, {31'b0, es});
    check("cyc_hi", HI, m_hi);
    check("cyc_lo", LO, m_lo);
    check("cyc_result", Result, er);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic run_long(input string nm, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic dis, input int exp_n,
                          input logic [31:0] eh, input logic [31:0] el);
    int nb, ns;
    Start = 1; MDop = op; A = a; B = b; D_IsMD = dis;
    #1;
    ns = Stall_MD ? 1 : 0;
    nb = 0;
    tick();
    Start = 0; MDop = 0; A = $urandom; B = $urandom;
    for (int k = 0; k < exp_n + 4; k++) begin
      #1;
      if (Busy) nb++;
      if (Stall_MD) ns++;
      tick();
    end
    check({nm, "_busy_cycles"}, nb, exp_n);
    check({nm, "_stall_cycles"}, ns, dis ? exp_n + 1 : 0);
    check({nm, "_hi"}, HI, eh);
    check({nm, "_lo"}, LO, el);
    check({nm, "_model_hi"}, m_hi, eh);
    check({nm, "_model_lo"}, m_lo, el);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: pick = 32'h0;
      1: pick = 32'h8000_0000;
      2: pick = 32'hFFFF_FFFF;
      3: pick = 32'($urandom_range(0, 20));
      default: pick = $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] op;
    logic st;
    int n;
    Reset_n = 0; Start = 0; MDop = 0; A = 0; B = 0; D_IsMD = 0;
    tick(); tick();
    check("reset_busy", {31'b0, Busy}, 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    Reset_n = 1;
    tick();

    run_long("mult", 4'd1, 32'hFFFF_FFFD, 32'd5, 1'b0, MC, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_long("multu", 4'd2, 32'hFFFF_FFFD, 32'd5, 1'b0, MC, 32'h0000_0004, 32'hFFFF_FFF1);
    run_long("divu", 4'd4, 32'd100, 32'd7, 1'b0, DC, 32'd2, 32'd14);
    run_long("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_long("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, DC, 32'h0, 32'h8000_0000);

    Start = 1; MDop = 5; A = 32'h1234_5678; B = 0; D_IsMD = 1;
    #1;
    check("mthi_stall", {31'b0, Stall_MD}, 32'd0);
    tick();
    Start = 1; MDop = 7; A = 0; D_IsMD = 0;
    #1;
    check("mfhi_result", Result, 32'h1234_5678);
    check("mfhi_busy", {31'b0, Busy}, 32'd0);
    tick();
    Start = 1; MDop = 5; A = 32'h11; tick();
    Start = 1; MDop = 6; A = 32'h22; tick();
    run_long("div0", 4'd3, 32'd8, 32'd0, 1'b0, DC, 32'h11, 32'h22);

    run_long("hazard", 4'd1, 32'd7, 32'd6, 1'b1, MC, 32'h0, 32'h2A);
    D_IsMD = 0;

    Start = 1; MDop = 3; A = 32'd100; B = 32'd7; tick();
    Start = 0; MDop = 0; tick(); tick();
    Reset_n = 0;
    #1;
    check("midrst_busy", {31'b0, Busy}, 32'd0);
    check("midrst_hi", HI, 32'd0);
    check("midrst_lo", LO, 32'd0);
    tick();
    Reset_n = 1;
    tick();
    run_long("post_rst_mult", 4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, MC, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

    for (int it = 0; it < 150; it++) begin
      op = 4'($urandom_range(0, 15));
      st = ($urandom_range(0, 3) != 0);
      Start = st; MDop = op; A = pick(); B = pick(); D_IsMD = 1'($urandom_range(0, 1));
      tick();
      if (st && op >= 1 && op <= 4) begin
        n = (op <= 2) ? MC : DC;
        for (int k = 0; k < n; k++) begin
          Start = 0; MDop = 4'($urandom_range(0, 15)); A = $urandom; B = $urandom;
          D_IsMD = 1'($urandom_range(0, 1));
          tick();
        end
      end
    end
    Start = 0; MDop = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
